// File: rtl/sync_fifo_pkg.sv
// Shared constants and elaboration helpers for the sync_fifo_v2 family.
package sync_fifo_pkg;

    localparam int RD_MODE_REG  = 0;
    localparam int RD_MODE_FWFT = 1;

    // Depth must be a power of two so wrap-bit pointers roll over naturally.
    function automatic bit is_pow2(input int value);
        return (value >= 2) && ((value & (value - 1)) == 0);
    endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// FIFO storage: one synchronous write port, one asynchronous read port.
module sync_fifo_ram #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  i_wr_en,
    input  logic [ADDR_WIDTH-1:0] i_wr_addr,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    input  logic [ADDR_WIDTH-1:0] i_rd_addr,
    output logic [DATA_WIDTH-1:0] o_rd_data
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    // NOTE: storage has no reset; the pointers alone decide which words are live.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/sync_fifo_v2.sv
// Single-clock FIFO with registered or FWFT read, occupancy flags and sticky errors.
// Define SYNC_FIFO_WATERMARK_EN to add the max_level high-water-mark output.
module sync_fifo_v2
    import sync_fifo_pkg::*;
#(
    parameter int  DATA_WIDTH   = 8,
    parameter int  DEPTH        = 8,
    parameter int  RD_MODE      = RD_MODE_REG,
    parameter int  AFULL_LEVEL  = DEPTH - 1,
    parameter int  AEMPTY_LEVEL = 1,
    localparam int ADDR_WIDTH   = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic                  clr_err,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
`ifdef SYNC_FIFO_WATERMARK_EN
    ,
    output logic [ADDR_WIDTH:0]   max_level
`endif
);

    if (!is_pow2(DEPTH)) begin : g_bad_depth
        $error("sync_fifo_v2: DEPTH must be a power of two and at least 2");
    end
    if (RD_MODE != RD_MODE_REG && RD_MODE != RD_MODE_FWFT) begin : g_bad_mode
        $error("sync_fifo_v2: RD_MODE must be 0 (registered) or 1 (FWFT)");
    end

    localparam logic [ADDR_WIDTH:0] C_ONE    = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH:0] C_DEPTH  = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] C_AFULL  = (ADDR_WIDTH + 1)'(AFULL_LEVEL);
    localparam logic [ADDR_WIDTH:0] C_AEMPTY = (ADDR_WIDTH + 1)'(AEMPTY_LEVEL);

    logic [ADDR_WIDTH:0]   r_wr_ptr;
    logic [ADDR_WIDTH:0]   r_rd_ptr;
    logic [ADDR_WIDTH:0]   r_count;
    logic                  r_overflow;
    logic                  r_underflow;

    logic [ADDR_WIDTH:0]   w_wr_ptr_next;
    logic [ADDR_WIDTH:0]   w_rd_ptr_next;
    logic [ADDR_WIDTH:0]   w_count_next;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_req_ok;
    logic                  w_wr_accept;
    logic                  w_rd_accept;
    logic                  w_ovf_event;
    logic                  w_unf_event;
    logic [DATA_WIDTH-1:0] w_ram_rd_data;

    assign w_full  = (r_count == C_DEPTH);
    assign w_empty = (r_count == '0);

    // Flush and reset both override the requests, so neither moves data nor flags errors.
    assign w_req_ok    = !rst && !flush;
    assign w_wr_accept = w_req_ok && wr_en && !w_full;
    assign w_rd_accept = w_req_ok && rd_en && !w_empty;
    assign w_ovf_event = w_req_ok && wr_en && w_full;
    assign w_unf_event = w_req_ok && rd_en && w_empty;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_wr_ptr_next = r_wr_ptr;
        w_rd_ptr_next = r_rd_ptr;
        w_count_next  = r_count;
        if (flush) begin
            w_wr_ptr_next = '0;
            w_rd_ptr_next = '0;
            w_count_next  = '0;
        end else begin
            if (w_wr_accept) begin
                w_wr_ptr_next = r_wr_ptr + C_ONE;
            end
            if (w_rd_accept) begin
                w_rd_ptr_next = r_rd_ptr + C_ONE;
            end
            unique case ({w_wr_accept, w_rd_accept})
                2'b10:   w_count_next = r_count + C_ONE;
                2'b01:   w_count_next = r_count - C_ONE;
                default: w_count_next = r_count;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_wr_ptr    <= w_wr_ptr_next;
            r_rd_ptr    <= w_rd_ptr_next;
            r_count     <= w_count_next;
            r_overflow  <= w_ovf_event || (r_overflow && !clr_err);
            r_underflow <= w_unf_event || (r_underflow && !clr_err);
        end
    end

    sync_fifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk       (clk),
        .i_wr_en   (w_wr_accept),
        .i_wr_addr (r_wr_ptr[ADDR_WIDTH-1:0]),
        .i_wr_data (wr_data),
        .i_rd_addr (r_rd_ptr[ADDR_WIDTH-1:0]),
        .o_rd_data (w_ram_rd_data)
    );

    if (RD_MODE == RD_MODE_FWFT) begin : g_fwft
        // Head word is presented directly; zero while empty so stale storage never leaks out.
        assign rd_data  = w_empty ? '0 : w_ram_rd_data;
        assign rd_valid = !w_empty;
    end else begin : g_reg
        logic [DATA_WIDTH-1:0] r_rd_data;
        logic                  r_rd_valid;

        always_ff @(posedge clk) begin
            if (rst) begin
                r_rd_data  <= '0;
                r_rd_valid <= 1'b0;
            end else begin
                r_rd_valid <= w_rd_accept;
                if (w_rd_accept) begin
                    r_rd_data <= w_ram_rd_data;
                end
            end
        end

        assign rd_data  = r_rd_data;
        assign rd_valid = r_rd_valid;
    end

`ifdef SYNC_FIFO_WATERMARK_EN
    logic [ADDR_WIDTH:0] r_max_level;

    // A clear restarts tracking from the occupancy being entered this edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_max_level <= '0;
        end else if (clr_err) begin
            r_max_level <= w_count_next;
        end else if (w_count_next > r_max_level) begin
            r_max_level <= w_count_next;
        end
    end

    assign max_level = r_max_level;
`endif

    assign full         = w_full;
    assign empty        = w_empty;
    assign almost_full  = (r_count >= C_AFULL);
    assign almost_empty = (r_count <= C_AEMPTY);
    assign count        = r_count;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

endmodule

// File: tb/tb_sync_fifo_v2.sv
// Self-checking bench: a registered-read and an FWFT instance share stimulus and a queue model.
module tb_sync_fifo_v2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       flush = 1'b0;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       rd_en = 1'b0;
    logic       clr_err = 1'b0;

    logic [7:0] rg_rd_data, ff_rd_data;
    logic       rg_rd_valid, ff_rd_valid;
    logic       rg_full, ff_full, rg_empty, ff_empty;
    logic       rg_afull, ff_afull, rg_aempty, ff_aempty;
    logic [3:0] rg_count, ff_count;
    logic       rg_ovf, ff_ovf, rg_unf, ff_unf;
`ifdef SYNC_FIFO_WATERMARK_EN
    logic [3:0] rg_max, ff_max;
`endif

    int n_checks = 0;
    int n_fail = 0;

    // Reference model: a plain queue plus the registered-read output latch.
    logic [7:0] mq[$];
    bit         m_ovf, m_unf, m_reg_valid;
    logic [7:0] m_reg_data;
    int         m_max;

    always #5 clk = ~clk;

    sync_fifo_v2 #(.DATA_WIDTH(8), .DEPTH(8), .RD_MODE(0)) dut_reg (
        .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .wr_data(wr_data),
        .rd_en(rd_en), .clr_err(clr_err), .rd_data(rg_rd_data), .rd_valid(rg_rd_valid),
        .full(rg_full), .empty(rg_empty), .almost_full(rg_afull), .almost_empty(rg_aempty),
        .count(rg_count), .overflow(rg_ovf), .underflow(rg_unf)
`ifdef SYNC_FIFO_WATERMARK_EN
        , .max_level(rg_max)
`endif
    );

    sync_fifo_v2 #(.DATA_WIDTH(8), .DEPTH(8), .RD_MODE(1)) dut_fwft (
        .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .wr_data(wr_data),
        .rd_en(rd_en), .clr_err(clr_err), .rd_data(ff_rd_data), .rd_valid(ff_rd_valid),
        .full(ff_full), .empty(ff_empty), .almost_full(ff_afull), .almost_empty(ff_aempty),
        .count(ff_count), .overflow(ff_ovf), .underflow(ff_unf)
`ifdef SYNC_FIFO_WATERMARK_EN
        , .max_level(ff_max)
`endif
    );

    task automatic model_edge();
        int  n;
        bit  wa, ra;
        n = mq.size();
        if (rst) begin
            mq.delete();
            m_ovf = 0; m_unf = 0; m_reg_valid = 0; m_reg_data = 8'h00; m_max = 0;
            return;
        end
        if (flush) begin
            mq.delete();
            m_reg_valid = 0;
            m_ovf = m_ovf && !clr_err;
            m_unf = m_unf && !clr_err;
        end else begin
            wa = wr_en && (n < 8);
            ra = rd_en && (n > 0);
            m_ovf = (wr_en && n == 8) || (m_ovf && !clr_err);
            m_unf = (rd_en && n == 0) || (m_unf && !clr_err);
            m_reg_valid = ra;
            if (ra) m_reg_data = mq.pop_front();
            if (wa) mq.push_back(wr_data);
        end
        if (clr_err) m_max = mq.size();
        else if (mq.size() > m_max) m_max = mq.size();
    endtask

    // Drive one cycle of inputs, advance the model at the edge, settle before checks.
    task automatic cycle(input bit w, input logic [7:0] d, input bit r,
                         input bit f = 0, input bit c = 0, input bit rs = 0);
        wr_en = w; wr_data = d; rd_en = r; flush = f; clr_err = c; rst = rs;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        cycle(0, 8'h00, 0, 0, 0, 1);
        cycle(0, 8'h00, 0, 0, 0, 1);
        n_checks++; if (rg_count !== 4'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", rg_count); end
        n_checks++; if ({rg_empty, rg_full, rg_aempty, rg_afull} !== 4'b1010) begin n_fail++; $display("FAIL reset_flags: got %b expected 1010", {rg_empty, rg_full, rg_aempty, rg_afull}); end
        n_checks++; if ({rg_rd_valid, ff_rd_valid, rg_ovf, rg_unf} !== 4'b0000) begin n_fail++; $display("FAIL reset_status: got %b expected 0000", {rg_rd_valid, ff_rd_valid, rg_ovf, rg_unf}); end
        n_checks++; if (rg_rd_data !== 8'h00) begin n_fail++; $display("FAIL reset_rd_data: got %h expected 00", rg_rd_data); end
    endtask

    task automatic test_fill_drain();
        for (int i = 1; i <= 8; i++) begin
            cycle(1, 8'(i), 0);
            n_checks++; if (rg_count !== 4'(i)) begin n_fail++; $display("FAIL fill_count: got %0d expected %0d", rg_count, i); end
            n_checks++; if (rg_afull !== (i >= 7)) begin n_fail++; $display("FAIL fill_afull at %0d: got %b expected %b", i, rg_afull, i >= 7); end
            n_checks++; if (rg_full !== (i == 8)) begin n_fail++; $display("FAIL fill_full at %0d: got %b expected %b", i, rg_full, i == 8); end
            n_checks++; if (rg_aempty !== (i <= 1)) begin n_fail++; $display("FAIL fill_aempty at %0d: got %b expected %b", i, rg_aempty, i <= 1); end
        end
        for (int i = 1; i <= 8; i++) begin
            n_checks++; if (ff_rd_data !== 8'(i)) begin n_fail++; $display("FAIL fwft_head: got %h expected %h", ff_rd_data, 8'(i)); end
            cycle(0, 8'h00, 1);
            n_checks++; if (rg_rd_valid !== 1'b1 || rg_rd_data !== 8'(i)) begin n_fail++; $display("FAIL drain_data: got %b/%h expected 1/%h", rg_rd_valid, rg_rd_data, 8'(i)); end
            cycle(0, 8'h00, 0);
            n_checks++; if (rg_rd_valid !== 1'b0 || rg_rd_data !== 8'(i)) begin n_fail++; $display("FAIL drain_hold: got %b/%h expected 0/%h", rg_rd_valid, rg_rd_data, 8'(i)); end
        end
        n_checks++; if (rg_empty !== 1'b1 || ff_rd_valid !== 1'b0) begin n_fail++; $display("FAIL drain_empty: got %b/%b expected 1/0", rg_empty, ff_rd_valid); end
    endtask

    task automatic test_overflow();
        logic [7:0] wdata [8];
        for (int i = 0; i < 8; i++) begin
            wdata[i] = 8'($urandom_range(0, 255));
            if (wdata[i] == 8'hAA) wdata[i] = 8'h5A;
            cycle(1, wdata[i], 0);
        end
        cycle(1, 8'hAA, 0);
        n_checks++; if (rg_count !== 4'd8 || rg_ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_set: got count %0d ovf %b expected 8/1", rg_count, rg_ovf); end
        cycle(0, 8'h00, 0);
        n_checks++; if (rg_ovf !== 1'b1 || ff_ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b/%b expected 1/1", rg_ovf, ff_ovf); end
        cycle(0, 8'h00, 0, 0, 1);
        n_checks++; if (rg_ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_clear: got %b expected 0", rg_ovf); end
        for (int i = 0; i < 8; i++) begin
            cycle(0, 8'h00, 1);
            n_checks++; if (rg_rd_data !== wdata[i]) begin n_fail++; $display("FAIL ovf_readback %0d: got %h expected %h", i, rg_rd_data, wdata[i]); end
        end
    endtask

    task automatic test_underflow();
        cycle(0, 8'h00, 1);
        n_checks++; if (rg_unf !== 1'b1 || rg_rd_valid !== 1'b0) begin n_fail++; $display("FAIL unf_set: got %b/%b expected 1/0", rg_unf, rg_rd_valid); end
        cycle(1, 8'h55, 1);
        n_checks++; if (rg_count !== 4'd1 || rg_rd_valid !== 1'b0) begin n_fail++; $display("FAIL unf_write: got count %0d valid %b expected 1/0", rg_count, rg_rd_valid); end
        n_checks++; if (ff_rd_data !== 8'h55) begin n_fail++; $display("FAIL unf_fwft_data: got %h expected 55", ff_rd_data); end
        cycle(0, 8'h00, 0, 0, 1);
        n_checks++; if (rg_unf !== 1'b0) begin n_fail++; $display("FAIL unf_clear: got %b expected 0", rg_unf); end
        cycle(0, 8'h00, 1);
        cycle(0, 8'h00, 1, 0, 1);
        n_checks++; if (rg_unf !== 1'b1 || ff_unf !== 1'b1) begin n_fail++; $display("FAIL unf_set_wins: got %b/%b expected 1/1", rg_unf, ff_unf); end
        cycle(0, 8'h00, 0, 0, 1);
    endtask

    task automatic test_fwft();
        logic [7:0] exp_head;
        cycle(1, 8'h3C, 0);
        n_checks++; if (ff_rd_valid !== 1'b1 || ff_rd_data !== 8'h3C) begin n_fail++; $display("FAIL fwft_first: got %b/%h expected 1/3c", ff_rd_valid, ff_rd_data); end
        n_checks++; if (rg_rd_valid !== 1'b0) begin n_fail++; $display("FAIL reg_no_autoread: got %b expected 0", rg_rd_valid); end
        for (int i = 0; i < 3; i++) cycle(1, 8'($urandom_range(0, 255)), 0);
        for (int i = 0; i < 4; i++) begin
            exp_head = mq[0];
            cycle(1, 8'($urandom_range(0, 255)), 1);
            n_checks++; if (ff_count !== 4'd4) begin n_fail++; $display("FAIL simul_count: got %0d expected 4", ff_count); end
            n_checks++; if (rg_rd_data !== exp_head || ff_rd_data !== mq[0]) begin n_fail++; $display("FAIL simul_order: got %h/%h expected %h/%h", rg_rd_data, ff_rd_data, exp_head, mq[0]); end
        end
    endtask

    task automatic test_wrap();
        logic [7:0] exp_head;
        for (int k = 0; k < 20; k++) begin
            cycle(1, 8'($urandom_range(0, 255)), 0);
            n_checks++; if (rg_count !== 4'd5 || rg_full !== 1'b0) begin n_fail++; $display("FAIL wrap_write %0d: got count %0d full %b expected 5/0", k, rg_count, rg_full); end
            exp_head = mq[0];
            cycle(0, 8'h00, 1);
            n_checks++; if (rg_rd_data !== exp_head || rg_empty !== 1'b0) begin n_fail++; $display("FAIL wrap_read %0d: got %h empty %b expected %h/0", k, rg_rd_data, rg_empty, exp_head); end
            n_checks++; if (ff_rd_data !== mq[0]) begin n_fail++; $display("FAIL wrap_fwft %0d: got %h expected %h", k, ff_rd_data, mq[0]); end
        end
    endtask

    task automatic test_flush();
        cycle(0, 8'h00, 0, 0, 1);
        cycle(1, 8'h11, 0);
        cycle(1, 8'h99, 0, 1);
        n_checks++; if (rg_count !== 4'd0 || rg_empty !== 1'b1) begin n_fail++; $display("FAIL flush_count: got %0d/%b expected 0/1", rg_count, rg_empty); end
        n_checks++; if (ff_rd_valid !== 1'b0 || rg_rd_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid: got %b/%b expected 0/0", ff_rd_valid, rg_rd_valid); end
`ifdef SYNC_FIFO_WATERMARK_EN
        n_checks++; if (rg_max !== 4'd5 || ff_max !== 4'd5) begin n_fail++; $display("FAIL flush_max_level: got %0d/%0d expected 5", rg_max, ff_max); end
`endif
        cycle(1, 8'h77, 0);
        cycle(0, 8'h00, 1);
        n_checks++; if (rg_rd_data !== 8'h77 || rg_empty !== 1'b1) begin n_fail++; $display("FAIL flush_discard: got %h/%b expected 77/1", rg_rd_data, rg_empty); end
    endtask

    task automatic test_reset_midstream();
        cycle(0, 8'h00, 1);
        for (int i = 0; i < 3; i++) cycle(1, 8'hC0 + 8'(i), 0);
        cycle(0, 8'h00, 1);
        cycle(1, 8'hEE, 1, 0, 0, 1);
        n_checks++; if (rg_count !== 4'd0 || rg_empty !== 1'b1 || ff_count !== 4'd0) begin n_fail++; $display("FAIL rst_mid_count: got %0d/%0d expected 0", rg_count, ff_count); end
        n_checks++; if ({rg_rd_valid, ff_rd_valid, rg_unf, rg_ovf} !== 4'b0000 || rg_rd_data !== 8'h00) begin n_fail++; $display("FAIL rst_mid_status: got %b/%h expected 0000/00", {rg_rd_valid, ff_rd_valid, rg_unf, rg_ovf}, rg_rd_data); end
        cycle(0, 8'h00, 0);
    endtask

    task automatic test_random();
        bit w, r, f, c;
        int sz;
        for (int i = 0; i < 400; i++) begin
            if ((i / 50) % 2 == 0) begin
                w = ($urandom_range(0, 9) < 8); r = ($urandom_range(0, 9) < 3);
            end else begin
                w = ($urandom_range(0, 9) < 3); r = ($urandom_range(0, 9) < 8);
            end
            f = ($urandom_range(0, 63) == 0);
            c = ($urandom_range(0, 15) == 0);
            cycle(w, 8'($urandom_range(0, 255)), r, f, c);
            sz = mq.size();
            n_checks++; if (rg_count !== 4'(sz) || ff_count !== 4'(sz)) begin n_fail++; $display("FAIL rnd_count %0d: got %0d/%0d expected %0d", i, rg_count, ff_count, sz); end
            n_checks++; if ({rg_full, rg_empty, rg_afull, rg_aempty} !== {sz == 8, sz == 0, sz >= 7, sz <= 1}) begin n_fail++; $display("FAIL rnd_flags %0d: got %b expected %b", i, {rg_full, rg_empty, rg_afull, rg_aempty}, {sz == 8, sz == 0, sz >= 7, sz <= 1}); end
            n_checks++; if ({ff_full, ff_empty, ff_afull, ff_aempty} !== {sz == 8, sz == 0, sz >= 7, sz <= 1}) begin n_fail++; $display("FAIL rnd_fflags %0d: got %b expected %b", i, {ff_full, ff_empty, ff_afull, ff_aempty}, {sz == 8, sz == 0, sz >= 7, sz <= 1}); end
            n_checks++; if ({rg_ovf, rg_unf, ff_ovf, ff_unf} !== {m_ovf, m_unf, m_ovf, m_unf}) begin n_fail++; $display("FAIL rnd_err %0d: got %b expected %b", i, {rg_ovf, rg_unf, ff_ovf, ff_unf}, {m_ovf, m_unf, m_ovf, m_unf}); end
            n_checks++; if (rg_rd_valid !== m_reg_valid || rg_rd_data !== m_reg_data) begin n_fail++; $display("FAIL rnd_reg_read %0d: got %b/%h expected %b/%h", i, rg_rd_valid, rg_rd_data, m_reg_valid, m_reg_data); end
            n_checks++; if (ff_rd_valid !== (sz > 0)) begin n_fail++; $display("FAIL rnd_fwft_valid %0d: got %b expected %b", i, ff_rd_valid, sz > 0); end
            if (sz > 0) begin
                n_checks++; if (ff_rd_data !== mq[0]) begin n_fail++; $display("FAIL rnd_fwft_data %0d: got %h expected %h", i, ff_rd_data, mq[0]); end
            end
`ifdef SYNC_FIFO_WATERMARK_EN
            n_checks++; if (rg_max !== 4'(m_max)) begin n_fail++; $display("FAIL rnd_max_level %0d: got %0d expected %0d", i, rg_max, m_max); end
`endif
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_fill_drain();
        test_overflow();
        test_underflow();
        test_fwft();
        test_wrap();
        test_flush();
        test_reset_midstream();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
